// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: padder FSM encoding and block geometry.
// Round constants and initial hash values will live here as well.
package sha256_pkg;

  typedef enum logic [2:0] {
    ST_DATA,
    ST_PAD_ONE,
    ST_PAD_ZERO,
    ST_LEN_HI,
    ST_LEN_LO
  } pad_state_e;

  localparam logic [7:0] PAD_BYTE        = 8'h80;
  localparam int         BLOCK_WORDS     = 16;
  localparam int         LEN_WORD_HI_IDX = 14;
  localparam int         IDX_W           = $clog2(BLOCK_WORDS);

endpackage

// File: rtl/sha256_pad_merge.sv
// Final-word merge: keeps the valid MSB-aligned bytes, drops the rest
// and places the 0x80 pad byte in the first unused lane.
module sha256_pad_merge
  import sha256_pkg::*;
(
  input  logic [31:0] data_i,
  input  logic [1:0]  nbytes_i,
  output logic [31:0] word_o
);

  // Byte-lane select on the count of valid bytes (0 means a full word).
  always_comb begin
    word_o = data_i;
    unique case (nbytes_i)
      2'd1:    word_o = {data_i[31:24], PAD_BYTE, 16'h0000};
      2'd2:    word_o = {data_i[31:16], PAD_BYTE, 8'h00};
      2'd3:    word_o = {data_i[31:8], PAD_BYTE};
      default: word_o = data_i;
    endcase
  end

endmodule

// File: rtl/sha256_msg_padder.sv
// SHA-256 message padder: 32-bit word stream in, 16-word blocks out.
// Define SHA256_PAD_ENDIAN_SWAP_EN to accept little-endian input words.
module sha256_msg_padder
  import sha256_pkg::*;
#(
  parameter int LEN_W = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] in_data,
  input  logic [1:0]  in_nbytes,
  input  logic        in_last,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_first,
  output logic        out_blk_last,
  output logic        out_msg_last
);

  pad_state_e       state_q;
  logic [IDX_W-1:0] idx_q;
  logic [LEN_W-1:0] len_q;
  logic [31:0]      out_data_q;
  logic             out_valid_q;
  logic             out_first_q;
  logic             out_blk_last_q;
  logic             out_msg_last_q;

  logic [31:0]      in_word;
  logic [31:0]      merged;
  logic             can_load;
  logic             in_fire;
  logic [IDX_W-1:0] idx_nxt;
  pad_state_e       pad_nxt;
  logic [5:0]       len_add_d;
  logic [LEN_W-1:0] len_d;
  logic [63:0]      len64;
  logic             ld_en;
  logic [31:0]      ld_data;
  logic             ld_msg;

`ifdef SHA256_PAD_ENDIAN_SWAP_EN
  assign in_word = {in_data[7:0], in_data[15:8],
                    in_data[23:16], in_data[31:24]};
`else
  assign in_word = in_data;
`endif

  sha256_pad_merge u_merge (
    .data_i   (in_word),
    .nbytes_i (in_nbytes),
    .word_o   (merged)
  );

  assign can_load = !out_valid_q || out_ready;
  assign in_ready = reset && (state_q == ST_DATA) && can_load;
  assign in_fire  = in_valid && in_ready;
  assign idx_nxt  = idx_q + 1'b1;

  // Padding hands over to the length words once index 14 is next.
  assign pad_nxt = (idx_nxt == IDX_W'(LEN_WORD_HI_IDX))
                 ? ST_LEN_HI : ST_PAD_ZERO;

  assign len_add_d = (in_last && in_nbytes != 2'd0)
                   ? {1'b0, in_nbytes, 3'b000} : 6'd32;
  assign len_d     = len_q + LEN_W'(len_add_d);
  assign len64     = 64'(len_q);

  // Select the word loaded into the output register this cycle.
  always_comb begin
    ld_en   = 1'b0;
    ld_data = 32'h0000_0000;
    ld_msg  = 1'b0;
    unique case (state_q)
      ST_DATA: begin
        ld_en   = in_fire;
        ld_data = in_last ? merged : in_word;
      end
      ST_PAD_ONE: begin
        ld_en   = can_load;
        ld_data = {PAD_BYTE, 24'h000000};
      end
      ST_PAD_ZERO: begin
        ld_en   = can_load;
      end
      ST_LEN_HI: begin
        ld_en   = can_load;
        ld_data = len64[63:32];
      end
      ST_LEN_LO: begin
        ld_en   = can_load;
        ld_data = len64[31:0];
        ld_msg  = 1'b1;
      end
      default: ;
    endcase
  end

  // Output register, word index, length counter and padding FSM.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_DATA;
      idx_q          <= '0;
      len_q          <= '0;
      out_data_q     <= 32'h0000_0000;
      out_valid_q    <= 1'b0;
      out_first_q    <= 1'b0;
      out_blk_last_q <= 1'b0;
      out_msg_last_q <= 1'b0;
    end else begin
      if (ld_en) begin
        out_data_q     <= ld_data;
        out_valid_q    <= 1'b1;
        out_first_q    <= (idx_q == '0);
        out_blk_last_q <= (idx_q == IDX_W'(BLOCK_WORDS - 1));
        out_msg_last_q <= ld_msg;
        idx_q          <= idx_nxt;
        unique case (state_q)
          ST_DATA: begin
            len_q <= len_d;
            if (in_last) begin
              state_q <= (in_nbytes == 2'd0) ? ST_PAD_ONE : pad_nxt;
            end
          end
          ST_PAD_ONE:  state_q <= pad_nxt;
          ST_PAD_ZERO: state_q <= pad_nxt;
          ST_LEN_HI:   state_q <= ST_LEN_LO;
          ST_LEN_LO: begin
            state_q <= ST_DATA;
            len_q   <= '0;
          end
          default:     state_q <= ST_DATA;
        endcase
      end else if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_data     = out_data_q;
  assign out_valid    = out_valid_q;
  assign out_first    = out_first_q;
  assign out_blk_last = out_blk_last_q;
  assign out_msg_last = out_msg_last_q;

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Directed bench for sha256_msg_padder: padding vectors, backpressure
// hold behaviour and mid-message reset.
module tb_sha256_msg_padder;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] in_data = '0;
  logic [1:0]  in_nbytes = '0;
  logic        in_last = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        out_first;
  logic        out_blk_last;
  logic        out_msg_last;

  int          n_cmp = 0;
  int          n_bad = 0;
  bit          bp_en = 1'b0;
  logic [34:0] got_q[$];
  logic [34:0] exp_q[$];
  logic [31:0] msg_q[$];

  sha256_msg_padder #(.LEN_W(64)) dut (
    .clock        (clock),
    .reset        (reset),
    .in_data      (in_data),
    .in_nbytes    (in_nbytes),
    .in_last      (in_last),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_first    (out_first),
    .out_blk_last (out_blk_last),
    .out_msg_last (out_msg_last)
  );

  initial forever #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
    end
  endtask

  // Downstream ready: always high, or random when backpressure is on.
  initial forever begin
    @(posedge clock);
    #2;
    out_ready = bp_en ? ($urandom_range(0, 1) == 1) : 1'b1;
  end

  // Output monitor: collects transfers, checks hold during stalls.
  initial begin
    bit          stall;
    logic [34:0] held;
    logic [34:0] cur;
    stall = 1'b0;
    held  = '0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        stall = 1'b0;
      end else begin
        cur = {out_data, out_first, out_blk_last, out_msg_last};
        if (stall) chk("hold", 64'(cur), 64'(held));
        if (out_valid && !out_ready) begin
          chk("stall_in_ready", 64'(in_ready), 64'd0);
          held  = cur;
          stall = 1'b1;
        end else begin
          stall = 1'b0;
        end
        if (out_valid && out_ready) got_q.push_back(cur);
      end
    end
  end

  task automatic exp_word(input logic [31:0] w, input bit msg);
    int p;
    p = exp_q.size() % 16;
    exp_q.push_back({w, p == 0, p == 15, msg});
  endtask

  task automatic exp_zeros(input int n);
    for (int i = 0; i < n; i++) exp_word(32'h0, 1'b0);
  endtask

  task automatic send(input logic [1:0] nb, input bit has_last);
    int t;
    @(posedge clock);
    #2;
    foreach (msg_q[i]) begin
      in_data   = msg_q[i];
      in_last   = has_last && (i == msg_q.size() - 1);
      in_nbytes = in_last ? nb : 2'd0;
      in_valid  = 1'b1;
      t = 0;
      do begin
        @(negedge clock);
        t++;
      end while (!in_ready && t < 500);
      if (!in_ready) begin
        chk("send_timeout", 64'(in_ready), 64'd1);
        break;
      end
      @(posedge clock);
      #2;
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_nbytes = 2'd0;
    msg_q.delete();
  endtask

  task automatic wait_out(input string name);
    int t;
    t = 0;
    while (got_q.size() < exp_q.size() && t < 3000) begin
      @(negedge clock);
      t++;
    end
    repeat (6) @(negedge clock);
    chk({name, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    foreach (exp_q[i]) begin
      if (i < got_q.size())
        chk($sformatf("%s_w%0d", name, i),
            64'(got_q[i]), 64'(exp_q[i]));
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic exp_abc();
    exp_word(32'h6162_6380, 1'b0);
    exp_zeros(14);
    exp_word(32'h0000_0018, 1'b1);
  endtask

  initial begin
    repeat (2) @(posedge clock);
    #2;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_first", 64'(out_first), 64'd0);
    chk("rst_out_blk_last", 64'(out_blk_last), 64'd0);
    chk("rst_out_msg_last", 64'(out_msg_last), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    reset = 1'b1;

    msg_q.push_back(32'h6162_6300);
    exp_abc();
    send(2'd3, 1'b1);
    wait_out("abc");

    msg_q.push_back(32'hda95_3d90);
    exp_word(32'hda95_3d90, 1'b0);
    exp_word(32'h8000_0000, 1'b0);
    exp_zeros(13);
    exp_word(32'h0000_0020, 1'b1);
    send(2'd0, 1'b1);
    wait_out("one_word");

    msg_q.push_back(32'h1122_3344);
    msg_q.push_back(32'h5500_0000);
    exp_word(32'h1122_3344, 1'b0);
    exp_word(32'h5580_0000, 1'b0);
    exp_zeros(13);
    exp_word(32'h0000_0028, 1'b1);
    send(2'd1, 1'b1);
    wait_out("five_bytes");

    for (int i = 0; i < 13; i++) begin
      msg_q.push_back(32'h2000_0000 + 32'(i));
      exp_word(32'h2000_0000 + 32'(i), 1'b0);
    end
    msg_q.push_back(32'haabb_0000);
    exp_word(32'haabb_8000, 1'b0);
    exp_word(32'h0000_0000, 1'b0);
    exp_word(32'h0000_01b0, 1'b1);
    send(2'd2, 1'b1);
    wait_out("pad_at_13");

    for (int i = 0; i < 14; i++) begin
      msg_q.push_back(32'h1000_0000 + 32'(i));
      exp_word(32'h1000_0000 + 32'(i), 1'b0);
    end
    exp_word(32'h8000_0000, 1'b0);
    exp_zeros(16);
    exp_word(32'h0000_01c0, 1'b1);
    send(2'd0, 1'b1);
    wait_out("words14");

    for (int i = 0; i < 16; i++) begin
      msg_q.push_back(32'h3000_0000 + 32'(i));
      exp_word(32'h3000_0000 + 32'(i), 1'b0);
    end
    exp_word(32'h8000_0000, 1'b0);
    exp_zeros(14);
    exp_word(32'h0000_0200, 1'b1);
    send(2'd0, 1'b1);
    wait_out("words16");

    bp_en = 1'b1;
    msg_q.push_back(32'h6162_6300);
    exp_abc();
    send(2'd3, 1'b1);
    wait_out("abc_bp");
    bp_en = 1'b0;

    for (int i = 0; i < 5; i++) msg_q.push_back(32'h4000_0000 + 32'(i));
    send(2'd0, 1'b0);
    repeat (3) @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_out_data", 64'(out_data), 64'd0);
    chk("mid_rst_out_first", 64'(out_first), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd0);
    got_q.delete();
    repeat (2) @(posedge clock);
    #2;
    reset = 1'b1;
    msg_q.push_back(32'h6162_6300);
    exp_abc();
    send(2'd3, 1'b1);
    wait_out("abc_after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
